// File: rtl/cla_pkg.sv
// Shared types and the group-carry lookahead network for cla_pipe_addsub.
package cla_pkg;

  localparam int unsigned CLA_MAX_STAGES = 3;
  // Widest group count the lookahead network covers. Must be a multiple of 4.
  localparam int unsigned CLA_MAX_GROUPS = 32;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Two-level lookahead: groups are clustered four to a super-group, super-group
  // carries are resolved first, then the carries inside each super-group.
  // Unused upper groups must be padded with g=0/p=0. Returns the carry into group idx;
  // idx == number of groups yields the carry out of the MSB group.
  function automatic logic lookahead(input gp_t [CLA_MAX_GROUPS-1:0] gp,
                                     input logic c0,
                                     input int unsigned idx);
    logic [CLA_MAX_GROUPS:0] c;
    logic sc;
    logic sg;
    logic sp;
    c  = '0;
    sc = c0;
    for (int s = 0; s < CLA_MAX_GROUPS / 4; s++) begin
      sg = 1'b0;
      sp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        sg = gp[4*s+j].g | (gp[4*s+j].p & sg);
        sp = sp & gp[4*s+j].p;
      end
      c[4*s] = sc;
      for (int j = 0; j < 3; j++) begin
        c[4*s+j+1] = gp[4*s+j].g | (gp[4*s+j].p & c[4*s+j]);
      end
      sc = sg | (sp & sc);
    end
    c[CLA_MAX_GROUPS] = sc;
    return c[idx];
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit adder slice producing its partial sum plus group generate/propagate.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             gg,
  output logic             pg
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;

  // Bit-level sum and group G/P; group G/P never depends on ci.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(GROUP) - 1; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s  = p ^ c;
    gg = 1'b0;
    pg = 1'b1;
    for (int i = 0; i < int'(GROUP); i++) begin
      gg = g[i] | (p[i] & gg);
      pg = pg & p[i];
    end
  end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Optional macro CLA_SAT_EN adds the sat port and signed saturation of the result.
// Group slices compute sums with carry-in 0; the final rank adds each group's
// lookahead carry back in (carry-increment), so the G/P rank needs no carries.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef CLA_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned NG = WIDTH / GROUP;

  typedef struct packed {
    logic [WIDTH-1:0] s0;
    gp_t  [NG-1:0]    gp;
    logic             c0;
    logic             a_msb;
    logic             b_msb;
    logic             sat;
  } gp_rank_t;

  typedef struct packed {
    logic [WIDTH-1:0] s0;
    logic [NG:0]      c;
    logic             a_msb;
    logic             b_msb;
    logic             sat;
  } cy_rank_t;

  logic [WIDTH-1:0]          b_eff;
  logic [WIDTH-1:0]          s0_w;
  gp_t  [NG-1:0]             gp_w;
  logic                      sat_in;
  gp_rank_t                  st0;
  gp_rank_t                  r1_d;
  logic                      r1_v;
  logic                      r1_ready;
  gp_t  [CLA_MAX_GROUPS-1:0] gp_pad;
  logic [NG:0]               carry;
  cy_rank_t                  st1;
  cy_rank_t                  r2_d;
  logic                      r2_v;
  logic                      r2_ready;
  logic                      ro_ready;
  logic [WIDTH-1:0]          sum_raw;
  logic [WIDTH-1:0]          sum_n;
  logic                      ovf_n;

`ifdef CLA_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  assign b_eff = sub ? ~b : b;

  // Group slices: partial sums with zero carry-in plus group G/P.
  for (genvar i = 0; i < int'(NG); i++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .a  (a[i*GROUP +: GROUP]),
      .b  (b_eff[i*GROUP +: GROUP]),
      .ci (1'b0),
      .s  (s0_w[i*GROUP +: GROUP]),
      .gg (gp_w[i].g),
      .pg (gp_w[i].p)
    );
  end

  // Bundle the G/P stage payload.
  always_comb begin
    st0       = '0;
    st0.s0    = s0_w;
    st0.gp    = gp_w;
    st0.c0    = sub ? 1'b1 : cin;
    st0.a_msb = a[WIDTH-1];
    st0.b_msb = b_eff[WIDTH-1];
    st0.sat   = sat_in;
  end

  if (STAGES >= 2) begin : g_r1
    gp_rank_t q;
    logic     v;
    // Rank after group G/P and partial sums.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v <= 1'b0;
        q <= '0;
      end else if (r1_ready) begin
        v <= in_valid;
        if (in_valid) q <= st0;
      end
    end
    assign r1_ready = !v | r2_ready;
    assign r1_v     = v;
    assign r1_d     = q;
  end else begin : g_nr1
    assign r1_ready = r2_ready;
    assign r1_v     = in_valid;
    assign r1_d     = st0;
  end

  assign in_ready = r1_ready;

  // Pad the G/P vector up to the lookahead network width.
  always_comb begin
    gp_pad         = '0;
    gp_pad[NG-1:0] = r1_d.gp;
  end

  for (genvar i = 0; i <= int'(NG); i++) begin : g_cy
    assign carry[i] = lookahead(gp_pad, r1_d.c0, i);
  end

  // Bundle the carry stage payload.
  always_comb begin
    st1       = '0;
    st1.s0    = r1_d.s0;
    st1.c     = carry;
    st1.a_msb = r1_d.a_msb;
    st1.b_msb = r1_d.b_msb;
    st1.sat   = r1_d.sat;
  end

  if (STAGES >= CLA_MAX_STAGES) begin : g_r2
    cy_rank_t q;
    logic     v;
    // Rank after the group carry network.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v <= 1'b0;
        q <= '0;
      end else if (r2_ready) begin
        v <= r1_v;
        if (r1_v) q <= st1;
      end
    end
    assign r2_ready = !v | ro_ready;
    assign r2_v     = v;
    assign r2_d     = q;
  end else begin : g_nr2
    assign r2_ready = ro_ready;
    assign r2_v     = r1_v;
    assign r2_d     = st1;
  end

  // Fold each group's carry back into its zero-carry partial sum.
  for (genvar i = 0; i < int'(NG); i++) begin : g_inc
    assign sum_raw[i*GROUP +: GROUP] = r2_d.s0[i*GROUP +: GROUP] + GROUP'(r2_d.c[i]);
  end

  // Signed overflow and optional saturation of the final sum.
  always_comb begin
    ovf_n = (r2_d.a_msb == r2_d.b_msb) & (sum_raw[WIDTH-1] != r2_d.a_msb);
    sum_n = sum_raw;
    if (r2_d.sat & ovf_n) begin
      sum_n = r2_d.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign ro_ready = !out_valid | out_ready;

  // Output rank: result and flags, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (ro_ready) begin
      out_valid <= r2_v;
      if (r2_v) begin
        sum  <= sum_n;
        cout <= r2_d.c[NG];
        ovf  <= ovf_n;
        zero <= (sum_n == '0);
        neg  <= sum_n[WIDTH-1];
      end
    end
  end

endmodule
